kfmmc_card_command_responder: RTL and testbench

//  Card-side end of the MMC/SD 1-bit CMD line, the counterpart of the host drive. Receives 48-bit

---
 rtl/kfmmc_card_pkg.sv | 38 +++
 rtl/kfmmc_crc7.sv | 22 ++
 rtl/kfmmc_card_command_responder.sv | 235 +++++++++++++++++++++++
 tb/tb_kfmmc_card_command_responder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/kfmmc_card_pkg.sv
// Shared types and constants for the card-side MMC/SD command responder.
package kfmmc_card_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECEIVE,
        ST_CHECK,
        ST_WAIT_RESPONSE,
        ST_DELAY,
        ST_SEND
    } state_t;

    // CRC7 generator x^7 + x^3 + 1 with the x^7 term implied.
    localparam logic [6:0] CRC7_POLY = 7'h09;

    localparam logic [7:0] CMD_FRAME_LEN  = 8'd48;
    localparam logic [7:0] LONG_FRAME_LEN = 8'd136;

    // Bit positions inside a received 48-bit command frame.
    localparam int BIT_START        = 47;
    localparam int BIT_TRANSMISSION = 46;
    localparam int BIT_END          = 0;

    // Receive bit counter value carrying frame bit 8, the last bit covered by CRC.
    localparam logic [7:0] RX_CRC_LAST_CNT = 8'd39;

    // Lowest and highest frame positions covered by the response CRC.
    localparam logic [7:0] TX_CRC_LOW_POS  = 8'd8;
    localparam logic [7:0] TX_CRC_HIGH_POS = 8'd127;

    // One serial CRC7 step, MSB-first.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic feedback;
        feedback = bit_in ^ crc[6];
        return {crc[5:0], 1'b0} ^ (feedback ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/kfmmc_crc7.sv
// Serial CRC7 accumulator; clear has priority over enable.
module kfmmc_crc7
    import kfmmc_card_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic       bit_in,
    output logic [6:0] crc
);

    // Accumulate one bit per enabled cycle.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            crc <= 7'h00;
        end else if (enable) begin
            crc <= crc7_step(crc, bit_in);
        end
    end

endmodule

// File: rtl/kfmmc_card_command_responder.sv
// Card end of the MMC/SD CMD line: receives host commands, checks CRC7,
// hands index/argument to the back-end and sends its response after Ncr.
//
// Back-end handshake: response_start and response_skip are single-cycle
// requests that are only looked at while the block waits for a response
// (command_valid has pulsed and nothing has been decided yet). Skip wins if
// both are high in the same cycle. In every other state they are ignored.
module kfmmc_card_command_responder
    import kfmmc_card_pkg::*;
#(
    parameter int         sync_stages    = 2,
    parameter logic [7:0] response_delay = 8'd2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         mmc_clk,
    input  logic         mmc_cmd_in,
    output logic         mmc_cmd_out,
    output logic         mmc_cmd_io,
    output logic         command_busy,
    output logic         command_valid,
    output logic [5:0]   command_index,
    output logic [31:0]  command_argument,
    output logic         command_crc_error,
    input  logic         response_start,
    input  logic         response_skip,
    input  logic         response_long,
    input  logic         response_crc_enable,
    input  logic [135:0] response_frame
);

    logic [sync_stages-1:0] clk_sync;
    logic [sync_stages-1:0] cmd_sync;
    logic                   clk_prev;
    logic                   mmc_rise;
    logic                   mmc_fall;
    logic                   cmd_bit;

    state_t       state;
    state_t       state_next;
    logic [47:0]  rx_shift;
    logic [7:0]   rx_cnt;
    logic [7:0]   rise_cnt;
    logic [7:0]   tx_cnt;
    logic [7:0]   tx_len;
    logic [7:0]   tx_pos;
    logic [135:0] tx_frame;
    logic         tx_crc_en;
    logic         tx_bit;
    logic         tx_in_crc_region;

    logic         crc_clear;
    logic         crc_enable;
    logic         crc_bit;
    logic [6:0]   crc;

    logic         frame_ok;
    logic         crc_ok;
    logic         ncr_done;

    // Bring mmc_clk and CMD into the clock domain through matched-depth chains.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync <= '0;
            cmd_sync <= '1;
            clk_prev <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[sync_stages-2:0], mmc_clk};
            cmd_sync <= {cmd_sync[sync_stages-2:0], mmc_cmd_in};
            clk_prev <= clk_sync[sync_stages-1];
        end
    end

    assign mmc_rise = clk_sync[sync_stages-1] & ~clk_prev;
    assign mmc_fall = ~clk_sync[sync_stages-1] & clk_prev;
    assign cmd_bit  = cmd_sync[sync_stages-1];

    assign frame_ok = !rx_shift[BIT_START] && rx_shift[BIT_TRANSMISSION] && rx_shift[BIT_END];
    assign crc_ok   = (rx_shift[7:1] == crc);
    assign ncr_done = (rise_cnt >= response_delay);

    assign tx_pos           = tx_len - 8'd1 - tx_cnt;
    assign tx_in_crc_region = (tx_pos >= TX_CRC_LOW_POS) && (tx_pos <= TX_CRC_HIGH_POS);
    assign command_busy     = (state != ST_IDLE);

    // Value of the response bit at tx_cnt, with start/transmission/end forced and CRC inserted.
    always_comb begin
        tx_bit = tx_frame[tx_pos];
        if (tx_cnt == 8'd0 || tx_cnt == 8'd1) begin
            tx_bit = 1'b0;
        end else if (tx_pos == 8'd0) begin
            tx_bit = 1'b1;
        end else if (tx_crc_en && tx_pos <= 8'd7) begin
            tx_bit = crc[tx_pos[2:0] - 3'd1];
        end
    end

    // Next-state logic and control of the shared CRC (half duplex, RX then TX).
    always_comb begin
        state_next = state;
        crc_clear  = 1'b0;
        crc_enable = 1'b0;
        crc_bit    = cmd_bit;
        case (state)
            ST_IDLE: begin
                if (mmc_rise && !cmd_bit) begin
                    state_next = ST_RECEIVE;
                    crc_clear  = 1'b1;
                end
            end
            ST_RECEIVE: begin
                if (mmc_rise) begin
                    crc_enable = (rx_cnt <= RX_CRC_LAST_CNT);
                    if (rx_cnt == CMD_FRAME_LEN - 8'd1) begin
                        state_next = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                state_next = (frame_ok && crc_ok) ? ST_WAIT_RESPONSE : ST_IDLE;
            end
            ST_WAIT_RESPONSE: begin
                if (response_skip) begin
                    state_next = ST_IDLE;
                end else if (response_start) begin
                    state_next = ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (mmc_fall && ncr_done) begin
                    state_next = ST_SEND;
                    crc_clear  = 1'b1;
                end
            end
            ST_SEND: begin
                if (mmc_fall) begin
                    crc_bit    = tx_bit;
                    crc_enable = (tx_cnt < tx_len) && tx_in_crc_region;
                    if (tx_cnt == tx_len) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    kfmmc_crc7 u_crc7 (
        .clock  (clock),
        .reset  (reset),
        .clear  (crc_clear),
        .enable (crc_enable),
        .bit_in (crc_bit),
        .crc    (crc)
    );

    // State register, receive/transmit datapath and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= ST_IDLE;
            rx_shift          <= '0;
            rx_cnt            <= 8'd0;
            rise_cnt          <= 8'd0;
            tx_cnt            <= 8'd0;
            tx_len            <= CMD_FRAME_LEN;
            tx_frame          <= '0;
            tx_crc_en         <= 1'b0;
            mmc_cmd_out       <= 1'b1;
            mmc_cmd_io        <= 1'b0;
            command_valid     <= 1'b0;
            command_crc_error <= 1'b0;
            command_index     <= 6'd0;
            command_argument  <= 32'd0;
        end else begin
            state             <= state_next;
            command_valid     <= 1'b0;
            command_crc_error <= 1'b0;
            if ((state == ST_WAIT_RESPONSE || state == ST_DELAY) && mmc_rise && rise_cnt != 8'hFF) begin
                rise_cnt <= rise_cnt + 8'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (mmc_rise && !cmd_bit) begin
                        rx_shift <= '0;
                        rx_cnt   <= 8'd1;
                    end
                end
                ST_RECEIVE: begin
                    if (mmc_rise) begin
                        rx_shift <= {rx_shift[46:0], cmd_bit};
                        rx_cnt   <= rx_cnt + 8'd1;
                    end
                end
                ST_CHECK: begin
                    rise_cnt <= 8'd0;
                    if (frame_ok && !crc_ok) begin
                        command_crc_error <= 1'b1;
                    end
                    if (frame_ok && crc_ok) begin
                        command_valid    <= 1'b1;
                        command_index    <= rx_shift[45:40];
                        command_argument <= rx_shift[39:8];
                    end
                end
                ST_WAIT_RESPONSE: begin
                    if (!response_skip && response_start) begin
                        tx_len    <= response_long ? LONG_FRAME_LEN : CMD_FRAME_LEN;
                        tx_crc_en <= response_crc_enable;
                        tx_frame  <= response_frame;
                    end
                end
                ST_DELAY: begin
                    if (mmc_fall && ncr_done) begin
                        mmc_cmd_io  <= 1'b1;
                        mmc_cmd_out <= 1'b0;
                        tx_cnt      <= 8'd1;
                    end
                end
                ST_SEND: begin
                    if (mmc_fall) begin
                        if (tx_cnt == tx_len) begin
                            mmc_cmd_io  <= 1'b0;
                            mmc_cmd_out <= 1'b1;
                        end else begin
                            mmc_cmd_out <= tx_bit;
                            tx_cnt      <= tx_cnt + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_kfmmc_card_command_responder.sv
// Bench for the card command responder: acts as host (drives mmc_clk/CMD,
// samples the card on each mmc_clk rise) and as the card back-end.
module tb_kfmmc_card_command_responder;

    localparam int NCR = 2;

    typedef struct {
        string        name;
        logic [47:0]  cmd;
        int           mode;        // 1 start, 2 skip, 3 start+skip
        bit           lng;
        bit           ce;
        logic [135:0] resp;
        bit           exp_valid;
        bit           exp_err;
        bit           resp_given;  // exp_resp holds a literal expected frame
        logic [135:0] exp_resp;
        int           pause;       // host clock stops after this cmd bit (-1 none)
    } vec_t;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         mmc_clk = 1'b0;
    logic         mmc_cmd_in = 1'b1;
    logic         mmc_cmd_out;
    logic         mmc_cmd_io;
    logic         command_busy;
    logic         command_valid;
    logic [5:0]   command_index;
    logic [31:0]  command_argument;
    logic         command_crc_error;
    logic         response_start = 1'b0;
    logic         response_skip = 1'b0;
    logic         response_long = 1'b0;
    logic         response_crc_enable = 1'b0;
    logic [135:0] response_frame = '0;

    int           be_mode = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    int           valid_pulses = 0;
    int           err_pulses = 0;
    logic [1:0]   exp_q[$];
    logic [5:0]   model_index = 6'd0;
    logic [31:0]  model_arg = 32'd0;
    vec_t         tbl[9];

    kfmmc_card_command_responder dut (
        .clock               (clock),
        .reset               (reset),
        .mmc_clk             (mmc_clk),
        .mmc_cmd_in          (mmc_cmd_in),
        .mmc_cmd_out         (mmc_cmd_out),
        .mmc_cmd_io          (mmc_cmd_io),
        .command_busy        (command_busy),
        .command_valid       (command_valid),
        .command_index       (command_index),
        .command_argument    (command_argument),
        .command_crc_error   (command_crc_error),
        .response_start      (response_start),
        .response_skip       (response_skip),
        .response_long       (response_long),
        .response_crc_enable (response_crc_enable),
        .response_frame      (response_frame)
    );

    // Clock
    always #5 clock = ~clock;

    // Pulse counters
    always @(negedge clock) begin
        if (command_valid) valid_pulses++;
        if (command_crc_error) err_pulses++;
    end

    // Back-end: answers each command_valid with a one-cycle request
    initial begin
        forever begin
            @(negedge clock);
            response_start = 1'b0;
            response_skip  = 1'b0;
            if (command_valid) begin
                response_start = (be_mode == 1 || be_mode == 3);
                response_skip  = (be_mode == 2 || be_mode == 3);
            end
        end
    end

    // CRC7 as polynomial remainder of v[hi:lo] * x^7 modulo x^7+x^3+1
    function automatic logic [6:0] crc7_div(input logic [135:0] v, input int hi, input int lo);
        logic [142:0] m;
        m = '0;
        for (int i = hi; i >= lo; i--) m[i - lo + 7] = v[i];
        for (int i = hi - lo + 7; i >= 7; i--)
            if (m[i]) m[i -: 8] = m[i -: 8] ^ 8'h89;
        return m[6:0];
    endfunction

    // Frame the card is expected to put on the line
    function automatic logic [135:0] model_resp(input logic [135:0] f, input bit lng, input bit ce);
        logic [135:0] r;
        int len;
        len = lng ? 136 : 48;
        r = f;
        if (!lng) r[135:48] = '0;
        r[len - 1] = 1'b0;
        r[len - 2] = 1'b0;
        r[0] = 1'b1;
        if (ce) r[7:1] = crc7_div(r, lng ? 127 : 47, 8);
        return r;
    endfunction

    function automatic logic [47:0] make_cmd(input logic [5:0] idx, input logic [31:0] arg);
        logic [135:0] t;
        t = '0;
        t[47:8] = {2'b01, idx, arg};
        return {2'b01, idx, arg, crc7_div(t, 47, 8), 1'b1};
    endfunction

    function automatic vec_t mk_vec(input string name, input logic [47:0] cmd, input int mode,
                                    input bit lng, input bit ce, input logic [135:0] resp,
                                    input bit ev, input bit ee, input bit rg,
                                    input logic [135:0] er, input int pause);
        vec_t v;
        v.name = name; v.cmd = cmd; v.mode = mode; v.lng = lng; v.ce = ce; v.resp = resp;
        v.exp_valid = ev; v.exp_err = ee; v.resp_given = rg; v.exp_resp = er; v.pause = pause;
        return v;
    endfunction

    task automatic check_val(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // One host clock period: CMD changes with the fall, card sampled just before the rise
    task automatic mmc_period(input logic b, output logic io, output logic out);
        @(negedge clock);
        mmc_clk    = 1'b0;
        mmc_cmd_in = b;
        repeat (4) @(negedge clock);
        io  = mmc_cmd_io;
        out = mmc_cmd_out;
        mmc_clk = 1'b1;
        repeat (3) @(negedge clock);
    endtask

    task automatic send_cmd(input logic [47:0] cmd, input int pause);
        logic io, out;
        for (int i = 47; i >= 0; i--) begin
            mmc_period(cmd[i], io, out);
            if (47 - i == pause) begin
                repeat (200) @(negedge clock);
                check_val("busy_clock_stopped", command_busy, 1'b1);
            end
        end
    endtask

    task automatic run_cmd(input vec_t v);
        logic io, out;
        logic [1:0] e;
        logic [135:0] er;
        int len, nper, bad, io_cnt, v0, e0;
        bit resp;
        response_long       = v.lng;
        response_crc_enable = v.ce;
        response_frame      = v.resp;
        be_mode             = v.mode;
        len  = v.lng ? 136 : 48;
        resp = v.exp_valid && v.mode == 1;
        er   = v.resp_given ? v.exp_resp : model_resp(v.resp, v.lng, v.ce);
        nper = NCR + 1 + len + 2;
        exp_q.delete();
        for (int j = 1; j <= nper; j++) begin
            if (resp && j >= NCR + 1 && j < NCR + 1 + len) exp_q.push_back({1'b1, er[len - 1 - (j - NCR - 1)]});
            else exp_q.push_back(2'b01);
        end
        v0 = valid_pulses;
        e0 = err_pulses;
        send_cmd(v.cmd, v.pause);
        bad = 0;
        io_cnt = 0;
        for (int j = 1; j <= nper; j++) begin
            mmc_period(1'b1, io, out);
            if (io === 1'b1) io_cnt++;
            e = exp_q.pop_front();
            if ({io, out} !== e) bad++;
        end
        if (v.exp_valid) begin
            model_index = v.cmd[45:40];
            model_arg   = v.cmd[39:8];
        end
        check_val({v.name, ":valid_pulses"}, valid_pulses - v0, v.exp_valid);
        check_val({v.name, ":crc_error_pulses"}, err_pulses - e0, v.exp_err);
        check_val({v.name, ":index"}, command_index, model_index);
        check_val({v.name, ":argument"}, command_argument, model_arg);
        check_val({v.name, ":bad_line_periods"}, bad, 0);
        check_val({v.name, ":io_periods"}, io_cnt, resp ? len : 0);
        check_val({v.name, ":busy_end"}, command_busy, 1'b0);
    endtask

    initial begin
        logic io, out;
        logic [47:0] c;
        bit corrupt;
        vec_t rv;

        tbl[0] = mk_vec("cmd0", 48'h40_0000_0000_95, 2, 0, 0, '0, 1, 0, 0, '0, -1);
        tbl[1] = mk_vec("cmd0_badcrc", 48'h40_0000_0000_97, 1, 0, 0, '0, 0, 1, 0, '0, -1);
        tbl[2] = mk_vec("cmd8", 48'h48_0000_01AA_87, 1, 0, 1, 136'h08_0000_01AA_00, 1, 0,
                        1, 136'h08_0000_01AA_13, -1);
        tbl[3] = mk_vec("r2", make_cmd(6'd2, 32'd0), 1, 1, 1,
                        136'h3F_0123_4567_89AB_CDEF_FEDC_BA98_7654_3200, 1, 0, 0, '0, -1);
        tbl[4] = mk_vec("start_and_skip", make_cmd(6'd55, 32'h0001_0000), 3, 0, 1, 136'h37_0000_0120_00,
                        1, 0, 0, '0, -1);
        tbl[5] = mk_vec("cmd0_after", 48'h40_0000_0000_95, 2, 0, 0, '0, 1, 0, 0, '0, 20);
        tbl[6] = mk_vec("bad_transmission", 48'h00_0000_0000_95, 1, 0, 0, '0, 0, 0, 0, '0, -1);
        tbl[7] = mk_vec("bad_end_bit", 48'h40_0000_0000_94, 1, 0, 0, '0, 0, 0, 0, '0, -1);
        tbl[8] = mk_vec("r1_no_crc", make_cmd(6'd17, 32'h0000_1234), 1, 0, 0, 136'h11_0000_0900_FE,
                        1, 0, 0, '0, -1);

        // Reset state
        repeat (5) @(negedge clock);
        check_val("reset_cmd_out", mmc_cmd_out, 1'b1);
        check_val("reset_cmd_io", mmc_cmd_io, 1'b0);
        check_val("reset_busy", command_busy, 1'b0);
        check_val("reset_valid", command_valid, 1'b0);
        check_val("reset_crc_error", command_crc_error, 1'b0);
        check_val("reset_index", command_index, 6'd0);
        check_val("reset_argument", command_argument, 32'd0);
        reset = 1'b0;
        for (int j = 0; j < 3; j++) mmc_period(1'b1, io, out);

        // Directed table
        for (int k = 0; k < 9; k++) run_cmd(tbl[k]);

        // Reset while the card is sending, then a fresh command
        response_long = 1'b0; response_crc_enable = 1'b1;
        response_frame = 136'h08_0000_01AA_00; be_mode = 1;
        send_cmd(48'h48_0000_01AA_87, -1);
        for (int j = 1; j <= NCR + 1 + 20; j++) mmc_period(1'b1, io, out);
        check_val("midsend_driving", io, 1'b1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_val("midsend_reset_io", mmc_cmd_io, 1'b0);
        check_val("midsend_reset_out", mmc_cmd_out, 1'b1);
        check_val("midsend_reset_busy", command_busy, 1'b0);
        check_val("midsend_reset_index", command_index, 6'd0);
        reset = 1'b0;
        model_index = 6'd0;
        model_arg   = 32'd0;
        for (int j = 0; j < 3; j++) mmc_period(1'b1, io, out);
        run_cmd(tbl[2]);

        // Randomized commands against the model
        for (int k = 0; k < 8; k++) begin
            c = make_cmd(6'($urandom_range(0, 63)), $urandom());
            corrupt = ($urandom_range(0, 3) == 0);
            if (corrupt) c[$urandom_range(1, 7)] = ~c[$urandom_range(1, 7)] ^ 1'b0;
            // recompute corruption flag from the actual frame
            corrupt = (c[7:1] != crc7_div({88'd0, c}, 47, 8));
            rv = mk_vec("random", c, $urandom_range(1, 3), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)),
                        {$urandom(), $urandom(), $urandom(), $urandom(), 8'($urandom())},
                        !corrupt, corrupt, 0, '0, -1);
            run_cmd(rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
